// File: rtl/vector_elem_sequencer.sv
// vector_elem_sequencer
//   Element-loop controller for the bit-serial VPU datapath. A start command
//   latches vl/vsew/vill/vstart, works out how many elements are active, then
//   hands elements to the datapath one at a time over valid/ready. It also
//   tracks architectural vstart progress so that a kill can resume later.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             start request (only honoured while o_idle)
//   i_vl, i_vsew,
//   i_vill, i_vstart    vector CSR state for this instruction
//   i_kill              abort the running instruction (trap/flush)
//   i_elem_ready        datapath accepts the presented element
//   o_idle              sequencer is idle and can take a start
//   o_elem_valid        an element is presented
//   o_elem_idx          element index
//   o_byte_off          byte offset of that element in the register
//   o_elem_last         presented element is the final one
//   o_done / o_err      one-cycle completion pulse, err = rejected instruction
//   o_vstart            vstart progress value
module vector_elem_sequencer #(
  parameter int WIDTH = 32,
  parameter int VLEN  = 256
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [WIDTH-1:0]               i_vl,
  input  logic [2:0]                     i_vsew,
  input  logic                           i_vill,
  input  logic [WIDTH-1:0]               i_vstart,
  input  logic                           i_kill,
  input  logic                           i_elem_ready,
  output logic                           o_idle,
  output logic                           o_elem_valid,
  output logic [$clog2(VLEN/8)-1:0]      o_elem_idx,
  output logic [$clog2(VLEN/8)-1:0]      o_byte_off,
  output logic                           o_elem_last,
  output logic                           o_done,
  output logic                           o_err,
  output logic [WIDTH-1:0]               o_vstart
);

  localparam int IW = $clog2(VLEN/8);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [IW-1:0]    idx_q,    idx_d;
  logic [1:0]       sew_q,    sew_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] vstart_q, vstart_d;
  logic             err_q,    err_d;

  logic [WIDTH-1:0] vlmax, cnt_full, idx_ext;
  logic             xfer, last;

  // VLMAX = VLEN/8 >> sew; the clamp is done at full WIDTH so a huge vl
  // never aliases onto a small count.
  assign vlmax    = WIDTH'(VLEN/8) >> i_vsew[1:0];
  assign cnt_full = (i_vl < vlmax) ? i_vl : vlmax;

  assign idx_ext  = WIDTH'(idx_q);
  assign xfer     = (state_q == S_RUN) && i_elem_ready;
  assign last     = (idx_ext == cnt_q - WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sew_d    = sew_q;
    cnt_d    = cnt_q;
    vstart_d = vstart_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          sew_d = i_vsew[1:0];
          cnt_d = cnt_full;
          if (i_vill || i_vsew[2]) begin
            // rejected: vstart is left untouched for the trap handler
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (i_vstart >= cnt_full) begin
            state_d  = S_DONE;
            vstart_d = '0;
          end else begin
            state_d  = S_RUN;
            idx_d    = i_vstart[IW-1:0];
            vstart_d = i_vstart;
          end
        end
      end
      S_RUN: begin
        if (i_kill) begin
          // a transfer in the kill cycle still counts as accepted
          state_d  = S_IDLE;
          vstart_d = idx_ext + WIDTH'(xfer);
        end else if (xfer) begin
          if (last) begin
            state_d  = S_DONE;
            vstart_d = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      sew_q    <= '0;
      cnt_q    <= '0;
      vstart_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sew_q    <= sew_d;
      cnt_q    <= cnt_d;
      vstart_q <= vstart_d;
      err_q    <= err_d;
    end
  end

  assign o_idle       = (state_q == S_IDLE);
  assign o_elem_valid = (state_q == S_RUN);
  assign o_elem_idx   = idx_q;
  // idx < VLMAX, so the shifted value always fits inside the register
  assign o_byte_off   = idx_q << sew_q;
  assign o_elem_last  = (state_q == S_RUN) && last;
  assign o_done       = (state_q == S_DONE);
  assign o_err        = (state_q == S_DONE) && err_q;
  assign o_vstart     = (state_q == S_RUN) ? idx_ext : vstart_q;

endmodule

// File: tb/tb_vector_elem_sequencer.sv
module tb_vector_elem_sequencer;
  localparam int WIDTH = 32;
  localparam int VLEN  = 256;
  localparam int IW    = $clog2(VLEN/8);

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_start = 1'b0;
  logic [WIDTH-1:0] i_vl = '0;
  logic [2:0]       i_vsew = '0;
  logic             i_vill = 1'b0;
  logic [WIDTH-1:0] i_vstart = '0;
  logic             i_kill = 1'b0;
  logic             i_elem_ready = 1'b0;
  logic             o_idle, o_elem_valid, o_elem_last, o_done, o_err;
  logic [IW-1:0]    o_elem_idx, o_byte_off;
  logic [WIDTH-1:0] o_vstart;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] mvst = '0;   // model of architectural vstart

  vector_elem_sequencer #(.WIDTH(WIDTH), .VLEN(VLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_vl(i_vl),
    .i_vsew(i_vsew), .i_vill(i_vill), .i_vstart(i_vstart), .i_kill(i_kill),
    .i_elem_ready(i_elem_ready), .o_idle(o_idle), .o_elem_valid(o_elem_valid),
    .o_elem_idx(o_elem_idx), .o_byte_off(o_byte_off), .o_elem_last(o_elem_last),
    .o_done(o_done), .o_err(o_err), .o_vstart(o_vstart)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({o_idle, o_elem_valid, o_done, o_err, o_elem_last} !== 5'b10000)
      begin errors++; $display("FAIL %s ctl: got idle/vld/done/err/last=%b want 10000", tag,
        {o_idle, o_elem_valid, o_done, o_err, o_elem_last}); end
    checks++;
    if (o_elem_idx !== '0 || o_byte_off !== '0 || o_vstart !== '0)
      begin errors++; $display("FAIL %s data: idx=%0d off=%0d vstart=%0d want 0/0/0", tag,
        o_elem_idx, o_byte_off, o_vstart); end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_start = 1'b1; i_kill = 1'b1; i_elem_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    check_reset_vals("reset");
    i_rst = 1'b0; i_start = 1'b0; i_kill = 1'b0; i_elem_ready = 1'b0;
    mvst = '0;
  endtask

  // One instruction. mode: 0 ready=1, 1 random ready, 2 ready from pat (cyclic).
  // kill_e / rst_e: element index at which kill / reset hits (-1 = never).
  task automatic run_instr(input logic [WIDTH-1:0] vl, input logic [2:0] sew,
                           input logic vill, input logic [WIDTH-1:0] vst,
                           input int mode, input logic [7:0] pat,
                           input int kill_e, input logic kill_rdy, input int rst_e);
    longint vlmax, cnt, e;
    int cyc, pi;
    logic r;
    @(negedge i_clk);
    checks++;
    if (o_idle !== 1'b1) begin errors++; $display("FAIL idle_before_start: got %b want 1", o_idle); end
    i_start = 1'b1; i_vl = vl; i_vsew = sew; i_vill = vill; i_vstart = vst;
    i_kill = 1'($urandom_range(0, 1));          // ignored in IDLE
    i_elem_ready = 1'($urandom_range(0, 1));
    @(negedge i_clk);
    i_start = 1'b0; i_kill = 1'b0;
    if (vill || sew > 3) begin
      checks++;
      if (o_done !== 1'b1 || o_err !== 1'b1 || o_elem_valid !== 1'b0)
        begin errors++; $display("FAIL reject: done/err/vld=%b%b%b want 110", o_done, o_err, o_elem_valid); end
      checks++;
      if (o_vstart !== mvst) begin errors++; $display("FAIL reject_vstart: got %0d want %0d", o_vstart, mvst); end
      return;
    end
    vlmax = VLEN >> (3 + sew);
    cnt = (longint'(vl) < vlmax) ? longint'(vl) : vlmax;
    if (longint'(vst) >= cnt) begin
      mvst = '0;
      checks++;
      if (o_done !== 1'b1 || o_err !== 1'b0 || o_elem_valid !== 1'b0)
        begin errors++; $display("FAIL noop: done/err/vld=%b%b%b want 100", o_done, o_err, o_elem_valid); end
      checks++;
      if (o_vstart !== mvst) begin errors++; $display("FAIL noop_vstart: got %0d want 0", o_vstart); end
      return;
    end
    e = longint'(vst); cyc = 0; pi = 0;
    forever begin
      if (cyc++ > 4000) begin
        errors++; checks++; $display("FAIL timeout: element loop did not finish");
        i_elem_ready = 1'b0; return;
      end
      checks++;
      if (o_elem_valid !== 1'b1 || o_done !== 1'b0 || o_err !== 1'b0)
        begin errors++; $display("FAIL run_ctl e=%0d: vld/done/err=%b%b%b want 100", e, o_elem_valid, o_done, o_err); end
      checks++;
      if (o_elem_idx !== IW'(e) || o_byte_off !== IW'(e << sew))
        begin errors++; $display("FAIL run_idx: idx=%0d off=%0d want %0d/%0d", o_elem_idx, o_byte_off, e, e << sew); end
      checks++;
      if (o_elem_last !== (e == cnt - 1) || o_vstart !== WIDTH'(e))
        begin errors++; $display("FAIL run_last e=%0d: last=%b vstart=%0d want %b/%0d", e, o_elem_last, o_vstart, e == cnt - 1, e); end
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = pat[pi % 8];
      endcase
      pi++;
      if (e == rst_e) begin
        i_rst = 1'b1; i_start = 1'b1; i_kill = 1'b1; i_elem_ready = 1'b1;
        @(negedge i_clk);
        check_reset_vals("reset_midrun");
        i_rst = 1'b0; i_start = 1'b0; i_kill = 1'b0; i_elem_ready = 1'b0;
        mvst = '0;
        return;
      end
      if (e == kill_e) begin
        i_kill = 1'b1; i_elem_ready = kill_rdy;
        @(negedge i_clk);
        i_kill = 1'b0; i_elem_ready = 1'b0;
        mvst = WIDTH'(e + longint'(kill_rdy));
        checks++;
        if (o_idle !== 1'b1 || o_elem_valid !== 1'b0 || o_done !== 1'b0)
          begin errors++; $display("FAIL kill_ctl: idle/vld/done=%b%b%b want 100", o_idle, o_elem_valid, o_done); end
        checks++;
        if (o_vstart !== mvst) begin errors++; $display("FAIL kill_vstart: got %0d want %0d", o_vstart, mvst); end
        return;
      end
      i_elem_ready = r;
      // start while busy must be ignored, with garbage CSR values
      i_start = 1'($urandom_range(0, 1));
      i_vl = $urandom; i_vsew = 3'($urandom_range(0, 7)); i_vstart = $urandom;
      @(negedge i_clk);
      i_start = 1'b0;
      if (r) begin
        if (e == cnt - 1) begin
          mvst = '0;
          i_kill = 1'($urandom_range(0, 1));    // ignored in DONE
          checks++;
          if (o_done !== 1'b1 || o_err !== 1'b0 || o_elem_valid !== 1'b0)
            begin errors++; $display("FAIL done: done/err/vld=%b%b%b want 100", o_done, o_err, o_elem_valid); end
          checks++;
          if (o_vstart !== mvst) begin errors++; $display("FAIL done_vstart: got %0d want 0", o_vstart); end
          @(negedge i_clk);
          i_kill = 1'b0; i_elem_ready = 1'b0;
          checks++;
          if (o_idle !== 1'b1 || o_done !== 1'b0)
            begin errors++; $display("FAIL done_one_cycle: idle/done=%b%b want 10", o_idle, o_done); end
          return;
        end
        e++;
      end
    end
  endtask

  task automatic test_normal;      run_instr(5, 2, 0, 0, 0, 8'hFF, -1, 0, -1);             endtask
  task automatic test_vl_clamp;
    run_instr(100, 0, 0, 0, 0, 8'hFF, -1, 0, -1);
    run_instr(32'h8000_0003, 0, 0, 30, 0, 8'hFF, -1, 0, -1);  // no truncation of vl
  endtask
  task automatic test_backpressure; run_instr(3, 1, 0, 0, 2, 8'b1111_1001, -1, 0, -1);    endtask
  task automatic test_reject_noop;
    run_instr(4, 2, 0, 2, 0, 8'hFF, 3, 1'b0, -1);  // leave a nonzero vstart (3)
    run_instr(8, 0, 1, 0, 0, 8'hFF, -1, 0, -1);    // vill: vstart kept
    run_instr(8, 5, 0, 0, 0, 8'hFF, -1, 0, -1);    // illegal sew
    run_instr(4, 0, 0, 4, 0, 8'hFF, -1, 0, -1);    // no-op
  endtask
  task automatic test_kill;
    run_instr(4, 3, 0, 0, 0, 8'hFF, 2, 1'b0, -1);
    run_instr(4, 3, 0, 0, 0, 8'hFF, 2, 1'b1, -1);
  endtask
  task automatic test_reset_midrun;
    run_instr(10, 1, 0, 0, 0, 8'hFF, -1, 0, 3);
    run_instr(10, 1, 0, 6, 1, 8'hFF, -1, 0, -1);
  endtask
  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] vl, vst;
      logic [2:0] sew;
      int ke;
      sew = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      vl  = ($urandom_range(0, 7) == 0) ? $urandom : WIDTH'($urandom_range(0, 40));
      vst = WIDTH'($urandom_range(0, 35));
      ke  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
      run_instr(vl, sew, ($urandom_range(0, 9) == 0), vst, 1, 8'hFF,
                ke, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_vl_clamp;
    test_backpressure;
    test_reject_noop;
    test_kill;
    test_reset_midrun;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
